rgb_pwm_ctrl: RTL and testbench
===============================

RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PRESCALE, 47: PWM tick every PRESCALE+1 clk cycles (1 MHz at 48 MHz).
- FADE_DIV, 16: PWM periods per fade step, range 1..255.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock.
- rst, in, 1: asynchronous, active-high reset.
- wr_en, in, 1: register write strobe, one write per asserted cycle.
- wr_addr, in, 2: register select.
- wr_data, in, 32: write data.
- pwm_out, out, 3: PWM drive; bit0 blue, bit1 green, bit2 red; feeds the RGB LED driver PWM inputs.
- busy, out, 1: high while a fade is active.
- done, out, 1: one-cycle pulse when a fade completes.

Function
REQ-003 Register map SHALL be:
- addr 0 DUTY: wr_data[23:16]/[15:8]/[7:0] = red/green/blue target; immediate set.
- addr 1 FADE: same layout; ramped set.
- addr 2 CTRL: bit0 enable, bit1 invert.
- addr 3: write ignored, no state change.
REQ-004 Prescaler SHALL count 0..PRESCALE and emit a one-cycle tick on wrap; an 8-bit PWM counter SHALL increment on each tick and wrap 255->0 (period = 256 ticks).
REQ-005 Each channel SHALL hold cur (working duty) and act (applied duty); act SHALL load from cur only on the tick where the PWM counter wraps to 0.
REQ-006 pwm_out[i] SHALL equal enable AND (pwm_cnt < act_i), XOR invert, registered (1-cycle latency): duty 0 = always low, duty 255 = high 255/256; with enable=0, output is forced low before invert (invert=1 gives constant high).
REQ-007 FSM states SHALL be IDLE and FADE; busy = (state == FADE).
REQ-008 DUTY write SHALL set cur and target to wr_data in the next cycle and force IDLE; an active fade is aborted with no done pulse.
REQ-009 FADE write SHALL load target and enter FADE; if already in FADE, the target is replaced and the step counter is not reset.
REQ-010 In FADE, a step SHALL occur every FADE_DIV PWM-period wraps: each cur_i moves 1 toward target_i; channels at target hold.
REQ-011 When all cur_i equal target_i in FADE, the FSM SHALL return to IDLE on that cycle and pulse done for exactly one cycle; a FADE write equal to cur gives busy for 1 cycle, then done.
REQ-012 A write SHALL take priority over a fade step in the same cycle; the step is dropped.
REQ-013 CTRL changes SHALL take effect on pwm_out one cycle after the write, not at a period boundary.
REQ-014 Duties are unsigned 8-bit; a step SHALL never overshoot or wrap past 0 or 255.

Reset
REQ-015 rst high SHALL immediately clear prescaler, pwm_cnt, step counter, cur, act, target, enable, invert, pwm_out, busy and done, and put the FSM in IDLE, including mid-fade.
REQ-016 After rst deasserts, the first tick SHALL occur PRESCALE+1 cycles later.

Structure
REQ-017 Package rgb_pwm_pkg SHALL hold the register address constants, FSM state enum, channel index constants (BLUE=0, GREEN=1, RED=2) and the 8-bit duty type.
REQ-018 A sub-module rgb_pwm_chan (cur/act/target registers, step logic, compare) SHALL be instantiated three times; the prescaler, FSM and register decode stay in rgb_pwm_ctrl.

Verification (PRESCALE=0, FADE_DIV=1 unless stated)
REQ-019 Reset mid-fade: FADE 0x00FF00 then rst at cycle 100 -> pwm_out=0, busy=0 and done=0 in the same cycle; no done ever pulses.
REQ-020 Duty compare: CTRL=1, DUTY=0x000040 -> blue high exactly 64 of every 256 cycles from the next period; duty 0xFF gives 255/256 high; duty 0 gives constant low.
REQ-021 Fade: from 0, FADE 0x030000 -> busy for 3 periods, red act steps 1,2,3, done once, then busy=0.
REQ-022 Abort and retarget: during fade to 0x000080 (at blue=0x10), FADE 0x000000 -> fade reverses without reset of step count; DUTY 0x000020 during fade -> busy drops, no done, cur=0x20.
REQ-023 Write/step collision: DUTY write on a step cycle -> cur equals written value, not stepped.
REQ-024 Invert/enable: CTRL=0x2 -> pwm_out=3'b111 constant; CTRL=0x3 with DUTY 0 -> 3'b111; addr 3 write -> no state change.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// Shared constants and types for the RGB PWM controller: register map,
// FSM states, channel indices and the 8-bit duty type.
package rgb_pwm_pkg;

  localparam logic [1:0] ADDR_DUTY = 2'd0;
  localparam logic [1:0] ADDR_FADE = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_RSVD = 2'd3;

  localparam int CH_BLUE  = 0;
  localparam int CH_GREEN = 1;
  localparam int CH_RED   = 2;
  localparam int NUM_CH   = 3;

  typedef logic [7:0] duty_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_e;

  // Move one code toward the target; equal values hold, so no overshoot or wrap.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    duty_t res;
    res = cur;
    if (cur < tgt) begin
      res = cur + 8'd1;
    end else if (cur > tgt) begin
      res = cur - 8'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM colour channel: working/applied/target duty registers,
// fade step logic and the registered duty compare.
module rgb_pwm_chan
  import rgb_pwm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  set_duty,
  input  logic  set_fade,
  input  logic  step_en,
  input  logic  load_act,
  input  duty_t wr_val,
  input  duty_t pwm_cnt,
  input  logic  enable,
  input  logic  invert,
  output logic  pwm_o,
  output logic  at_target
);

  duty_t cur_q, cur_d;
  duty_t act_q, act_d;
  duty_t tgt_q, tgt_d;
  logic  pwm_q, pwm_d;

  always_comb begin
    cur_d = cur_q;
    tgt_d = tgt_q;
    act_d = act_q;
    if (set_duty) begin
      cur_d = wr_val;
      tgt_d = wr_val;
    end else if (set_fade) begin
      tgt_d = wr_val;
    end else if (step_en) begin
      cur_d = step_toward(cur_q, tgt_q);
    end else begin
      cur_d = cur_q;
    end
    // act samples the pre-step cur so a whole period uses one duty
    if (load_act) begin
      act_d = cur_q;
    end else begin
      act_d = act_q;
    end
    pwm_d = (enable & (pwm_cnt < act_q)) ^ invert;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= 8'd0;
      act_q <= 8'd0;
      tgt_q <= 8'd0;
      pwm_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      act_q <= act_d;
      tgt_q <= tgt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign at_target = (cur_q == tgt_q);

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// RGB PWM controller top: register decode, prescaler, 8-bit PWM counter,
// fade FSM and three colour channels.
module rgb_pwm_ctrl
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE = 47,
  parameter int FADE_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [2:0]  pwm_out,
  output logic        busy,
  output logic        done
);

  localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE);
  localparam logic [7:0]    FADE_LAST  = 8'(FADE_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  duty_t         pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    step_cnt_q, step_cnt_d;
  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic          inv_q, inv_d;
  logic          done_q, done_d;

  logic          tick, wrap, step_en;
  logic          wr_duty, wr_fade, wr_ctrl;
  logic [NUM_CH-1:0] at_target;
  logic [NUM_CH-1:0] pwm_ch;
  logic          unused_wr_bits;

  assign unused_wr_bits = ^wr_data[31:24];

  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    wrap      = tick && (pwm_cnt_q == 8'hFF);

    wr_duty = wr_en && (wr_addr == ADDR_DUTY);
    wr_fade = wr_en && (wr_addr == ADDR_FADE);
    wr_ctrl = wr_en && (wr_addr == ADDR_CTRL);

    // CTRL feeds the output compare directly so it lands one cycle after the write
    en_d  = wr_ctrl ? wr_data[0] : en_q;
    inv_d = wr_ctrl ? wr_data[1] : inv_q;
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    done_d     = 1'b0;
    step_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        step_cnt_d = 8'd0;
        if (wr_fade) begin
          state_d = ST_FADE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FADE: begin
        if (wrap) begin
          step_cnt_d = (step_cnt_q == FADE_LAST) ? 8'd0 : step_cnt_q + 8'd1;
        end else begin
          step_cnt_d = step_cnt_q;
        end
        // any write wins over the step and over completion in this cycle
        if (wr_duty) begin
          state_d    = ST_IDLE;
          step_cnt_d = 8'd0;
        end else if (wr_fade || wr_ctrl) begin
          state_d = ST_FADE;
        end else if (&at_target) begin
          state_d    = ST_IDLE;
          step_cnt_d = 8'd0;
          done_d     = 1'b1;
        end else begin
          step_en = wrap && (step_cnt_q == FADE_LAST);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        step_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      pwm_cnt_q  <= 8'd0;
      step_cnt_q <= 8'd0;
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      inv_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      state_q    <= state_d;
      en_q       <= en_d;
      inv_q      <= inv_d;
      done_q     <= done_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    rgb_pwm_chan u_chan (
      .clk       (clk),
      .rst       (rst),
      .set_duty  (wr_duty),
      .set_fade  (wr_fade),
      .step_en   (step_en),
      .load_act  (wrap),
      .wr_val    (wr_data[8*i +: 8]),
      .pwm_cnt   (pwm_cnt_q),
      .enable    (en_d),
      .invert    (inv_d),
      .pwm_o     (pwm_ch[i]),
      .at_target (at_target[i])
    );
  end

  assign pwm_out = pwm_ch;
  assign busy    = (state_q == ST_FADE);
  assign done    = done_q;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed self-checking bench for rgb_pwm_ctrl with PRESCALE=0, FADE_DIV=1
// (one PWM tick per clock, one fade step per 256-cycle period).
module tb_rgb_pwm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [2:0]  pwm_out;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int done_total = 0;
  logic [7:0] bc;  // expected PWM counter phase: one tick per clock

  rgb_pwm_ctrl #(.PRESCALE(0), .FADE_DIV(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pwm_out(pwm_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) bc <= 8'd0;
    else     bc <= bc + 8'd1;
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_total <= done_total + 1;
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 32'd0;
  endtask

  // returns at the negedge just after the next counter wrap
  task automatic wait_wrap();
    @(posedge clk);
    @(negedge clk);
    while (bc != 8'd0) @(negedge clk);
  endtask

  task automatic measure(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      r += int'(pwm_out[2]); g += int'(pwm_out[1]); b += int'(pwm_out[0]);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_duty();
    int r, g, b;
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h000040);
    repeat (520) @(negedge clk);
    measure(r, g, b);
    chk("duty40_blue", b, 64); chk("duty40_green", g, 0); chk("duty40_red", r, 0);
    wr(2'd0, 32'h0000FF);
    repeat (520) @(negedge clk);
    measure(r, g, b);
    chk("dutyFF_blue", b, 255);
    wr(2'd0, 32'h000000);
    repeat (520) @(negedge clk);
    measure(r, g, b);
    chk("duty0_blue", b, 0); chk("duty0_green", g, 0); chk("duty0_red", r, 0);
    wr(2'd0, 32'h00801002);
    repeat (520) @(negedge clk);
    measure(r, g, b);
    chk("mix_red", r, 128); chk("mix_green", g, 16); chk("mix_blue", b, 2);
  endtask

  task automatic test_fade();
    int r, g, b, n, d0;
    wr(2'd0, 32'h0);
    repeat (520) @(negedge clk);
    d0 = done_total;
    wait_wrap();
    wr(2'd1, 32'h030000);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 2000) begin n++; @(negedge clk); end
    chk("fade_busy_cycles", n, 767);
    @(posedge clk); #1;
    chk("fade_done_count", done_total - d0, 1);
    chk("fade_busy_after", int'(busy), 0);
    repeat (520) @(negedge clk);
    measure(r, g, b);
    chk("fade_red_final", r, 3);
  endtask

  task automatic test_fade_equal();
    wr(2'd1, 32'h030000);
    @(negedge clk);
    chk("eq_busy1", int'(busy), 1); chk("eq_done1", int'(done), 0);
    @(negedge clk);
    chk("eq_busy2", int'(busy), 0); chk("eq_done2", int'(done), 1);
    @(negedge clk);
    chk("eq_done3", int'(done), 0);
  endtask

  task automatic test_abort_retarget();
    int r, g, b, d0;
    wr(2'd0, 32'h0);
    d0 = done_total;
    wait_wrap();
    wr(2'd1, 32'h000080);
    repeat (16) wait_wrap();
    wr(2'd1, 32'h000000);
    repeat (15) wait_wrap();
    chk("rev_busy_mid", int'(busy), 1);
    wait_wrap();
    @(negedge clk);
    chk("rev_busy_end", int'(busy), 0);
    @(posedge clk); #1;
    chk("rev_done_count", done_total - d0, 1);
    wait_wrap();
    wr(2'd1, 32'h000080);
    repeat (5) wait_wrap();
    d0 = done_total;
    wr(2'd0, 32'h000020);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    repeat (600) @(negedge clk);
    chk("abort_no_done", done_total - d0, 0);
    measure(r, g, b);
    chk("abort_blue", b, 32);
  endtask

  task automatic test_collision();
    int r, g, b, d0;
    wr(2'd0, 32'h0);
    wait_wrap();
    wr(2'd1, 32'h000040);
    repeat (4) wait_wrap();
    while (bc != 8'd254) @(negedge clk);
    d0 = done_total;
    wr(2'd1, 32'h000008);  // lands on the wrap edge; that step is dropped
    repeat (4) wait_wrap();
    chk("coll_fade_busy", int'(busy), 1);
    @(negedge clk);
    chk("coll_fade_idle", int'(busy), 0);
    @(posedge clk); #1;
    chk("coll_fade_done", done_total - d0, 1);
    wr(2'd1, 32'h0000FF);
    repeat (3) wait_wrap();
    while (bc != 8'd254) @(negedge clk);
    wr(2'd0, 32'h000050);
    @(negedge clk);
    chk("coll_duty_busy", int'(busy), 0);
    repeat (520) @(negedge clk);
    measure(r, g, b);
    chk("coll_duty_blue", b, 80);
  endtask

  task automatic test_invert_enable();
    int n, bz;
    wr(2'd2, 32'h2);
    @(negedge clk);
    chk("inv_immediate", int'(pwm_out), 7);
    n = 0;
    for (int i = 0; i < 300; i++) begin @(negedge clk); if (pwm_out === 3'b111) n++; end
    chk("inv_constant", n, 300);
    wr(2'd0, 32'h0);
    repeat (520) @(negedge clk);
    wr(2'd2, 32'h3);
    n = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clk); if (pwm_out === 3'b111) n++; end
    chk("inv_en_duty0", n, 256);
    wr(2'd3, 32'hFFFFFFFF);
    n = 0; bz = 0;
    for (int i = 0; i < 776; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bz++;
      if (i >= 520 && pwm_out === 3'b111) n++;
    end
    chk("addr3_pwm", n, 256);
    chk("addr3_busy", bz, 0);
  endtask

  task automatic test_reset_mid_fade();
    int d0, bz;
    wr(2'd2, 32'h2);
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h00FF00);
    repeat (100) @(negedge clk);
    chk("mid_pre_busy", int'(busy), 1);
    chk("mid_pre_pwm", int'(pwm_out), 7);
    d0 = done_total;
    rst = 1'b1;
    #1;
    chk("mid_rst_pwm", int'(pwm_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bz = 0;
    for (int i = 0; i < 600; i++) begin @(negedge clk); if (busy !== 1'b0) bz++; end
    @(posedge clk); #1;
    chk("mid_post_done", done_total - d0, 0);
    chk("mid_post_busy", bz, 0);
  endtask

  initial begin
    test_reset();
    test_duty();
    test_fade();
    test_fade_equal();
    test_abort_retarget();
    test_collision();
    test_invert_enable();
    test_reset_mid_fade();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
